// File: rtl/pla_pkg.sv
// Shared types and helpers for the PLA configuration controller.
package pla_pkg;

    // Command encoding carried on cfg_cmd.
    typedef enum logic [1:0] {
        CMD_WRITE  = 2'b00,
        CMD_CLEAR  = 2'b01,
        CMD_COMMIT = 2'b10,
        CMD_RSVD   = 2'b11
    } cmd_e;

    // Controller states: IDLE accepts commands, the others are busy.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_WEN    = 2'd3
    } state_e;

    // Plane select on cfg_plane for WRITE commands.
    localparam logic PLANE_AND = 1'b0;
    localparam logic PLANE_OR  = 1'b1;

    // Larger of the two row counts; the clear sweep covers this many rows.
    function automatic int max_rows(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Row index width able to address the larger of the two planes.
    function automatic int ROW_W(input int a, input int b);
        int m;
        m = max_rows(a, b);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/pla_cfg_bank.sv
// Shadow + active register bank for one PLA plane. Rows are edited in the
// shadow copy; a commit copies every shadow row into the active copy in a
// single edge so the PLA never sees a partially updated plane.
module pla_cfg_bank #(
    parameter int ROWS  = 8,
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en_i,
    input  logic [IDX_W-1:0]      wr_row_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  clr_en_i,
    input  logic [IDX_W-1:0]      clr_row_i,
    input  logic                  commit_i,
    output logic [ROWS*WIDTH-1:0] active_o
);

    logic [WIDTH-1:0] shadow_q [ROWS];
    logic [WIDTH-1:0] active_q [ROWS];

    // Row edits land in the shadow bank; commit snapshots shadow into active.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < ROWS; r++) begin
                shadow_q[r] <= '0;
                active_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                // Clear and write never coincide: clears only run outside IDLE.
                if (clr_en_i && (int'(clr_row_i) == r)) begin
                    shadow_q[r] <= '0;
                end else if (wr_en_i && (int'(wr_row_i) == r)) begin
                    shadow_q[r] <= wr_data_i;
                end
                if (commit_i) begin
                    active_q[r] <= shadow_q[r];
                end
            end
        end
    end

    // Flatten the active rows onto the PLA select bus.
    for (genvar g = 0; g < ROWS; g++) begin : g_flat
        assign active_o[g*WIDTH +: WIDTH] = active_q[g];
    end

endmodule

// File: rtl/pla_cfg_ctrl.sv
// PLA configuration controller: valid/ready command front end, clear sweep
// and commit sequencing around two shadow/active banks (AND and OR planes).
module pla_cfg_ctrl
    import pla_pkg::*;
#(
    parameter  int IN_WIDTH  = 16,
    parameter  int OUT_WIDTH = 8,
    parameter  int AND_WIDTH = 32,
    localparam int RW        = ROW_W(AND_WIDTH, OUT_WIDTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic [1:0]                      cfg_cmd,
    input  logic                            cfg_plane,
    input  logic [RW-1:0]                   cfg_row,
    input  logic [2*IN_WIDTH-1:0]           cfg_data,
    output logic [AND_WIDTH*2*IN_WIDTH-1:0] and_sel,
    output logic [OUT_WIDTH*AND_WIDTH-1:0]  or_sel,
    output logic                            pla_wen,
    output logic                            cfg_loaded,
    output logic                            err
);

    localparam int            AW       = 2 * IN_WIDTH;
    localparam int            MAX_ROWS = max_rows(AND_WIDTH, OUT_WIDTH);
    localparam logic [RW-1:0] CLR_LAST = RW'(MAX_ROWS - 1);

    state_e                 state_q;
    logic [RW-1:0]          cnt_q;
    logic                   pla_wen_q;
    logic                   cfg_loaded_q;
    logic                   err_q;

    cmd_e                   cmd;
    logic                   accept;
    logic                   row_ok;
    logic                   and_wr;
    logic                   or_wr;
    logic                   and_clr;
    logic                   or_clr;
    logic                   commit;
    logic [AND_WIDTH-1:0]   or_wr_data;

    assign cmd       = cmd_e'(cfg_cmd);
    assign cfg_ready = (state_q == ST_IDLE);
    assign accept    = cfg_valid && cfg_ready;

    // A row index outside the addressed plane is accepted but ignored.
    assign row_ok = (cfg_plane == PLANE_AND) ? (int'(cfg_row) < AND_WIDTH)
                                             : (int'(cfg_row) < OUT_WIDTH);

    assign and_wr  = accept && (cmd == CMD_WRITE) && (cfg_plane == PLANE_AND) && row_ok;
    assign or_wr   = accept && (cmd == CMD_WRITE) && (cfg_plane == PLANE_OR)  && row_ok;

    // The sweep counter runs to the taller plane; the shorter one stops early.
    assign and_clr = (state_q == ST_CLEAR) && (int'(cnt_q) < AND_WIDTH);
    assign or_clr  = (state_q == ST_CLEAR) && (int'(cnt_q) < OUT_WIDTH);
    assign commit  = (state_q == ST_COMMIT);

    // OR rows are AND_WIDTH wide; take the low bits of the data word.
    if (AW >= AND_WIDTH) begin : g_or_trunc
        assign or_wr_data = cfg_data[AND_WIDTH-1:0];
    end else begin : g_or_pad
        assign or_wr_data = {{(AND_WIDTH-AW){1'b0}}, cfg_data};
    end

    // Command FSM with registered write-enable pulse, loaded and error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            pla_wen_q    <= 1'b0;
            cfg_loaded_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            pla_wen_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        case (cmd)
                            CMD_WRITE: begin
                                if (!row_ok) begin
                                    err_q <= 1'b1;
                                end
                            end
                            CMD_CLEAR: begin
                                cnt_q   <= '0;
                                state_q <= ST_CLEAR;
                            end
                            CMD_COMMIT: begin
                                state_q <= ST_COMMIT;
                            end
                            CMD_RSVD: begin
                                err_q <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_CLEAR: begin
                    if (cnt_q == CLR_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    // Banks copy on this edge; announce it in the next cycle.
                    pla_wen_q <= 1'b1;
                    state_q   <= ST_WEN;
                end
                ST_WEN: begin
                    cfg_loaded_q <= 1'b1;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign pla_wen    = pla_wen_q;
    assign cfg_loaded = cfg_loaded_q;
    assign err        = err_q;

    pla_cfg_bank #(
        .ROWS  (AND_WIDTH),
        .WIDTH (AW),
        .IDX_W (RW)
    ) u_and_bank (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .wr_en_i   (and_wr),
        .wr_row_i  (cfg_row),
        .wr_data_i (cfg_data),
        .clr_en_i  (and_clr),
        .clr_row_i (cnt_q),
        .commit_i  (commit),
        .active_o  (and_sel)
    );

    pla_cfg_bank #(
        .ROWS  (OUT_WIDTH),
        .WIDTH (AND_WIDTH),
        .IDX_W (RW)
    ) u_or_bank (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .wr_en_i   (or_wr),
        .wr_row_i  (cfg_row),
        .wr_data_i (or_wr_data),
        .clr_en_i  (or_clr),
        .clr_row_i (cnt_q),
        .commit_i  (commit),
        .active_o  (or_sel)
    );

endmodule

// File: tb/tb_pla_cfg_ctrl.sv
// Testbench for pla_cfg_ctrl: directed tables, hand-written latency and
// reset sequences, and random commands against a command-level model.
module tb_pla_cfg_ctrl;

    localparam int IN_WIDTH  = 16;
    localparam int OUT_WIDTH = 8;
    localparam int AND_WIDTH = 32;
    localparam int RW        = 5;
    localparam int AW        = 2 * IN_WIDTH;
    localparam int MAXR      = (AND_WIDTH > OUT_WIDTH) ? AND_WIDTH : OUT_WIDTH;

    localparam logic [1:0] C_WR  = 2'b00;
    localparam logic [1:0] C_CLR = 2'b01;
    localparam logic [1:0] C_CMT = 2'b10;
    localparam logic [1:0] C_RSV = 2'b11;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic                          cfg_valid = 1'b0;
    logic [1:0]                    cfg_cmd = 2'b00;
    logic                          cfg_plane = 1'b0;
    logic [RW-1:0]                 cfg_row = '0;
    logic [AW-1:0]                 cfg_data = '0;
    logic                          cfg_ready;
    logic [AND_WIDTH*AW-1:0]       and_sel;
    logic [OUT_WIDTH*AND_WIDTH-1:0] or_sel;
    logic                          pla_wen;
    logic                          cfg_loaded;
    logic                          err;

    pla_cfg_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_cmd    (cfg_cmd),
        .cfg_plane  (cfg_plane),
        .cfg_row    (cfg_row),
        .cfg_data   (cfg_data),
        .and_sel    (and_sel),
        .or_sel     (or_sel),
        .pla_wen    (pla_wen),
        .cfg_loaded (cfg_loaded),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Command-level model of the visible configuration state.
    logic [AW-1:0]        m_sh_and  [AND_WIDTH];
    logic [AW-1:0]        m_act_and [AND_WIDTH];
    logic [AND_WIDTH-1:0] m_sh_or   [OUT_WIDTH];
    logic [AND_WIDTH-1:0] m_act_or  [OUT_WIDTH];
    logic                 m_err;
    logic                 m_loaded;

    typedef struct {
        logic [1:0]    cmd;
        logic          plane;
        logic [RW-1:0] row;
        logic [AW-1:0] data;
        int            busy;
        logic          err;
        logic [AW-1:0] and_row3;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < AND_WIDTH; r++) begin
            m_sh_and[r]  = '0;
            m_act_and[r] = '0;
        end
        for (int r = 0; r < OUT_WIDTH; r++) begin
            m_sh_or[r]  = '0;
            m_act_or[r] = '0;
        end
        m_err    = 1'b0;
        m_loaded = 1'b0;
    endtask

    task automatic model_apply(input logic [1:0] c, input logic pl, input logic [RW-1:0] row,
                               input logic [AW-1:0] d);
        int idx;
        idx = int'(row);
        case (c)
            C_WR: begin
                if (pl == 1'b0) begin
                    if (idx < AND_WIDTH) m_sh_and[idx] = d;
                    else                 m_err = 1'b1;
                end else begin
                    if (idx < OUT_WIDTH) m_sh_or[idx] = d[AND_WIDTH-1:0];
                    else                 m_err = 1'b1;
                end
            end
            C_CLR: begin
                for (int r = 0; r < AND_WIDTH; r++) m_sh_and[r] = '0;
                for (int r = 0; r < OUT_WIDTH; r++) m_sh_or[r] = '0;
            end
            C_CMT: begin
                for (int r = 0; r < AND_WIDTH; r++) m_act_and[r] = m_sh_and[r];
                for (int r = 0; r < OUT_WIDTH; r++) m_act_or[r] = m_sh_or[r];
                m_loaded = 1'b1;
            end
            default: m_err = 1'b1;
        endcase
    endtask

    function automatic int exp_busy(input logic [1:0] c);
        if (c == C_CLR) return MAXR;
        if (c == C_CMT) return 2;
        return 0;
    endfunction

    // Compare both active banks against the model; one comparison per bank.
    task automatic chk_banks(input string nm);
        int bad;
        logic [AW-1:0] g;
        logic [AW-1:0] e;
        bad = -1;
        g = '0;
        e = '0;
        for (int r = 0; r < AND_WIDTH; r++) begin
            if (bad < 0 && and_sel[r*AW +: AW] !== m_act_and[r]) begin
                bad = r;
                g = and_sel[r*AW +: AW];
                e = m_act_and[r];
            end
        end
        n_cmp++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s and_sel row %0d: got %h expected %h", nm, bad, g, e);
        end
        bad = -1;
        for (int r = 0; r < OUT_WIDTH; r++) begin
            if (bad < 0 && or_sel[r*AND_WIDTH +: AND_WIDTH] !== m_act_or[r]) begin
                bad = r;
                g = or_sel[r*AND_WIDTH +: AND_WIDTH];
                e = m_act_or[r];
            end
        end
        n_cmp++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s or_sel row %0d: got %h expected %h", nm, bad, g, e);
        end
    endtask

    // Issue one command from a negedge, then wait (bounded) for ready again.
    task automatic send(input logic [1:0] c, input logic pl, input logic [RW-1:0] row,
                        input logic [AW-1:0] d, output int busy, output int wens);
        cfg_valid = 1'b1;
        cfg_cmd   = c;
        cfg_plane = pl;
        cfg_row   = row;
        cfg_data  = d;
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        busy = 0;
        wens = 0;
        while (!cfg_ready && busy < 200) begin
            if (pla_wen) wens++;
            busy++;
            @(negedge clk);
        end
        model_apply(c, pl, row, d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int busy;
        int wens;
        logic saw_wen;

        // ---------------- reset ----------------
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
        chk("t1_ready", cfg_ready, 1);
        chk("t1_loaded", cfg_loaded, 0);
        chk("t1_err", err, 0);
        chk("t1_wen", pla_wen, 0);
        chk_banks("t1");

        // ---------------- write then commit ----------------
        send(C_WR, 1'b0, 5'd3, 32'h0000_0003, busy, wens);
        chk("t2_wr_and_busy", busy, 0);
        send(C_WR, 1'b1, 5'd5, 32'h0000_0008, busy, wens);
        chk("t2_wr_or_busy", busy, 0);
        chk("t2_pre_and_row3", and_sel[3*AW +: AW], 0);
        chk("t2_pre_or_row5", or_sel[5*AND_WIDTH +: AND_WIDTH], 0);
        cfg_valid = 1'b1;
        cfg_cmd   = C_CMT;
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("t2_c1_ready", cfg_ready, 0);
        chk("t2_c1_and_row3", and_sel[3*AW +: AW], 0);
        chk("t2_c1_wen", pla_wen, 0);
        @(negedge clk);
        chk("t2_c2_ready", cfg_ready, 0);
        chk("t2_c2_and_row3", and_sel[3*AW +: AW], 32'h3);
        chk("t2_c2_or_row5", or_sel[5*AND_WIDTH +: AND_WIDTH], 32'h8);
        chk("t2_c2_wen", pla_wen, 1);
        chk("t2_c2_loaded", cfg_loaded, 0);
        @(negedge clk);
        chk("t2_c3_ready", cfg_ready, 1);
        chk("t2_c3_wen", pla_wen, 0);
        chk("t2_c3_loaded", cfg_loaded, 1);
        model_apply(C_CMT, 1'b0, '0, '0);
        chk_banks("t2_banks");

        // ---------------- clear sweep and error cases ----------------
        tbl[0] = '{C_CLR, 1'b0, 5'd0,  32'h0,         MAXR, 1'b0, 32'h3};
        tbl[1] = '{C_CMT, 1'b0, 5'd0,  32'h0,         2,    1'b0, 32'h0};
        tbl[2] = '{C_WR,  1'b1, 5'd8,  32'hDEAD_BEEF, 0,    1'b1, 32'h0};
        tbl[3] = '{C_RSV, 1'b0, 5'd0,  32'h0,         0,    1'b1, 32'h0};
        tbl[4] = '{C_WR,  1'b0, 5'd31, 32'hA5A5_5A5A, 0,    1'b1, 32'h0};
        tbl[5] = '{C_CMT, 1'b0, 5'd0,  32'h0,         2,    1'b1, 32'h0};
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].cmd, tbl[i].plane, tbl[i].row, tbl[i].data, busy, wens);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("tbl%0d_err", i), err, tbl[i].err);
            chk($sformatf("tbl%0d_ready", i), cfg_ready, 1);
            chk($sformatf("tbl%0d_and_row3", i), and_sel[3*AW +: AW], tbl[i].and_row3);
            chk_banks($sformatf("tbl%0d", i));
        end
        chk("t4_and_row31", and_sel[31*AW +: AW], 32'hA5A5_5A5A);

        // ---------------- backpressure ----------------
        send(C_WR, 1'b0, 5'd9, 32'h1111_2222, busy, wens);
        cfg_valid = 1'b1;
        cfg_cmd   = C_CMT;
        @(posedge clk);
        @(negedge clk);
        cfg_cmd   = C_WR;
        cfg_plane = 1'b0;
        cfg_row   = 5'd9;
        cfg_data  = 32'hCAFE_F00D;
        chk("t5_b1_ready", cfg_ready, 0);
        @(negedge clk);
        chk("t5_b2_ready", cfg_ready, 0);
        chk("t5_b2_wen", pla_wen, 1);
        @(negedge clk);
        chk("t5_idle_ready", cfg_ready, 1);
        chk("t5_idle_row9", and_sel[9*AW +: AW], 32'h1111_2222);
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        model_apply(C_CMT, 1'b0, '0, '0);
        model_apply(C_WR, 1'b0, 5'd9, 32'hCAFE_F00D);
        chk("t5_after_ready", cfg_ready, 1);
        chk("t5_after_wen", pla_wen, 0);
        chk_banks("t5_after");
        send(C_CMT, 1'b0, '0, '0, busy, wens);
        chk("t5_final_row9", and_sel[9*AW +: AW], 32'hCAFE_F00D);
        chk("t5_final_wens", wens, 1);
        chk_banks("t5_final");

        // ---------------- random commands ----------------
        for (int k = 0; k < 150; k++) begin
            int            sel;
            logic [1:0]    c;
            logic          pl;
            logic [RW-1:0] rw;
            logic [AW-1:0] d;
            sel = $urandom_range(0, 9);
            c   = (sel <= 5) ? C_WR : (sel == 6) ? C_CLR : (sel <= 8) ? C_CMT : C_RSV;
            pl  = 1'($urandom_range(0, 1));
            rw  = pl ? RW'($urandom_range(0, 9)) : RW'($urandom_range(0, AND_WIDTH-1));
            d   = AW'($urandom);
            send(c, pl, rw, d, busy, wens);
            chk($sformatf("rnd%0d_busy", k), busy, exp_busy(c));
            chk($sformatf("rnd%0d_wens", k), wens, (c == C_CMT) ? 1 : 0);
            chk($sformatf("rnd%0d_err", k), err, m_err);
            chk($sformatf("rnd%0d_loaded", k), cfg_loaded, m_loaded);
            chk_banks($sformatf("rnd%0d", k));
        end

        // ---------------- reset mid-clear ----------------
        send(C_WR, 1'b0, 5'd0, 32'hFFFF_0001, busy, wens);
        send(C_WR, 1'b1, 5'd7, 32'h8000_0001, busy, wens);
        send(C_CMT, 1'b0, '0, '0, busy, wens);
        chk_banks("t6_loaded");
        cfg_valid = 1'b1;
        cfg_cmd   = C_CLR;
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        saw_wen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (pla_wen) saw_wen = 1'b1;
            @(negedge clk);
        end
        chk("t6_mid_ready", cfg_ready, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_ready", cfg_ready, 1);
        chk("t6_rst_loaded", cfg_loaded, 0);
        chk("t6_rst_err", err, 0);
        chk_banks("t6_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (pla_wen || !cfg_ready) saw_wen = 1'b1;
            @(negedge clk);
        end
        chk("t6_no_wen_idle", saw_wen, 0);
        send(C_CMT, 1'b0, '0, '0, busy, wens);
        chk("t6_commit_busy", busy, 2);
        chk_banks("t6_post_commit");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pla_cfg_ctrl.md
Name: pla_cfg_ctrl

Overview:
Configuration controller for the PLA block. It accepts plane-programming commands over a valid/ready handshake and holds them in shadow AND/OR select banks. On commit it copies the shadow banks atomically into the active banks, which drive the PLA's andSel/orSel inputs, and pulses the PLA write-enable. A commit therefore never exposes the PLA to a half-written configuration.

Parameters:
IN_WIDTH, 16, PLA input count; each AND row is 2*IN_WIDTH bits (true and complement literal per input).
OUT_WIDTH, 8, PLA output count; number of OR rows.
AND_WIDTH, 32, product-term count; number of AND rows, and width of each OR row.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
cfg_valid  in  1  command valid.
cfg_ready  out  1  controller can accept a command.
cfg_cmd  in  2  00 WRITE, 01 CLEAR, 10 COMMIT, 11 reserved.
cfg_plane  in  1  WRITE target: 0 = AND plane, 1 = OR plane.
cfg_row  in  RW  row index; RW = $clog2(max(AND_WIDTH,OUT_WIDTH)).
cfg_data  in  2*IN_WIDTH  row data; OR-plane writes use bits [AND_WIDTH-1:0], upper bits ignored.
and_sel  out  AND_WIDTH*2*IN_WIDTH  active AND bank, flattened; row r at [r*2*IN_WIDTH +: 2*IN_WIDTH].
or_sel  out  OUT_WIDTH*AND_WIDTH  active OR bank, flattened; row r at [r*AND_WIDTH +: AND_WIDTH].
pla_wen  out  1  one-cycle pulse when the active banks change.
cfg_loaded  out  1  high once at least one commit has completed.
err  out  1  sticky error flag.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rst_n).
- Reset values: all shadow and active rows 0, state IDLE, cfg_ready 1, pla_wen 0, cfg_loaded 0, err 0, sweep counter 0.
- Handshake: a command is accepted on a rising edge where cfg_valid && cfg_ready.
  - cfg_ready = (state == IDLE), driven combinationally from the state register.
  - cfg_valid is never sampled outside IDLE.
  - The master must hold its fields stable while cfg_valid && !cfg_ready.
- FSM states: IDLE, CLEAR, COMMIT, WEN.
  - IDLE + WRITE: write the shadow row in the same edge and stay in IDLE. Back-to-back WRITEs are accepted every cycle.
  - IDLE + CLEAR: go to CLEAR with counter = 0.
  - CLEAR: each cycle zero shadow AND row[counter] (if counter < AND_WIDTH) and shadow OR row[counter] (if counter < OUT_WIDTH), then increment. When counter == max(AND_WIDTH,OUT_WIDTH)-1, return to IDLE. Duration is exactly max(AND_WIDTH,OUT_WIDTH) cycles; active banks are untouched.
  - IDLE + COMMIT: go to COMMIT.
  - COMMIT (1 cycle): active <= shadow for both planes in one edge; go to WEN.
  - WEN (1 cycle): pla_wen = 1; cfg_loaded <= 1; go to IDLE.
  - Latency: active banks update on the 1st edge after COMMIT acceptance; pla_wen is high during the following cycle; cfg_ready returns 2 cycles after acceptance.
- Boundary conditions:
  - WRITE with cfg_row >= AND_WIDTH (plane 0) or >= OUT_WIDTH (plane 1): accepted, no bank changes, err <= 1.
  - cmd 11: accepted as a NOP, err <= 1.
  - Shadow edits after a commit do not affect and_sel/or_sel until the next COMMIT.
  - COMMIT right after CLEAR zeroes the active banks.
  - err clears only on reset.
  - rst_n asserted mid-CLEAR or mid-COMMIT: every register returns to its reset value immediately. A partial clear is discarded; the active banks become 0.
- Storage: flat registers, with no memory macro, since every row must drive the PLA in parallel.

Decomposition:
- Shared package pla_pkg:
  - cmd enum: CMD_WRITE, CMD_CLEAR, CMD_COMMIT, CMD_RSVD.
  - state enum.
  - PLANE_AND/PLANE_OR constants.
  - ROW_W function (clog2 of max).
- One natural sub-module, pla_cfg_bank: a parameterised ROWS x WIDTH shadow+active register bank with row write, row clear, and bulk commit. It is instantiated twice, once for AND and once for OR. The FSM and handshake stay in pla_cfg_ctrl.

Test Plan:
1. Reset: drive rst_n=0 for 3 cycles, then release → and_sel=0, or_sel=0, cfg_ready=1, cfg_loaded=0, err=0, pla_wen=0.
2. Write then commit:
   - Stimulus: WRITE AND row 3 = 32'h0000_0003, WRITE OR row 5 = 32'h0000_0008, then COMMIT.
   - Before commit: and_sel/or_sel stay 0.
   - 1 edge after commit acceptance: and_sel[3*32+:32]=32'h3 and or_sel[5*32+:32]=32'h8.
   - Next cycle: pla_wen=1 for exactly one cycle and cfg_loaded=1.
   - cfg_ready low for exactly 2 cycles.
3. Clear sweep: after test 2, issue CLEAR → cfg_ready low for exactly 32 cycles; active banks unchanged. Then COMMIT → all rows 0.
4. Error cases:
   - WRITE OR row 8 → banks unchanged, err=1.
   - Then cmd 11 → err stays 1 and cfg_ready stays 1.
   - A following valid WRITE AND row 31 succeeds.
5. Backpressure: hold cfg_valid with a WRITE during COMMIT/WEN → it is accepted only on the first IDLE edge, and is written exactly once.
6. Reset mid-CLEAR: pull rst_n low at sweep count 10 → all banks 0, state IDLE, pla_wen never pulses.
